// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the instruction-fetch and data paths.
// Round-robin on ties, fixed wait-state access, one-cycle ack per transaction.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              last_dm;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              grant, grant_dm;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_dm  = last_dm;
    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          grant     = 1'b1;
          grant_dm  = (if_req && dm_req) ? ~last_dm : dm_req;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // last_dm doubles as the owner of the in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      last_dm  <= 1'b1;
      we_r     <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        addr_r  <= grant_dm ? dm_addr : if_addr;
        if (grant_dm) wdata_r <= dm_wdata;
        we_r    <= grant_dm & dm_we;
        last_dm <= grant_dm;
        cnt     <= 4'(WAIT_CYCLES - 1);
      end else if (state == ACCESS) begin
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else if (!we_r) begin
          if (last_dm) dm_rdata <= mem_rdata;
          else         if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_re    = (state == ACCESS) & ~we_r;
  assign mem_we    = (state == ACCESS) &  we_r;
  assign if_ack    = (state == DONE) & ~last_dm;
  assign dm_ack    = (state == DONE) &  last_dm;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected acks queued at drive time,
// popped and compared when the DUT acks.
module tb_mem_port_arbiter;
  localparam int WC = 2;

  logic        clk = 1'b0, reset = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic        if_ack, dm_ack, mem_re, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h2001000A;
      32'h200: return 32'h12345678;
      32'h80:  return 32'hA5A50001;
      default: return a ^ 32'hFFFF0000;
    endcase
  endfunction

  always_comb mem_rdata = mem_re ? mem_fn(mem_addr) : 32'h0;

  typedef struct packed {logic dm; logic [31:0] rdata;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic [31:0] exp_if_rd = '0, exp_dm_rd = '0;

  // Waits (bounded) for any ack, tallying strobe cycles seen on the way.
  task automatic wait_ack(input int max, output int cyc, output bit side_dm,
                          output int re_n, output int we_n,
                          output logic [31:0] a_seen, output logic [31:0] wd_seen);
    cyc = -1; side_dm = 0; re_n = 0; we_n = 0; a_seen = '0; wd_seen = '0;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if (mem_re) re_n++;
      if (mem_we) we_n++;
      if (mem_re || mem_we) begin a_seen = mem_addr; wd_seen = mem_wdata; end
      if (if_ack || dm_ack) begin cyc = k; side_dm = dm_ack; break; end
    end
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({if_ack, dm_ack, mem_re, mem_we, busy} !== 5'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs ctl=%b addr=%h wd=%h ifrd=%h dmrd=%h want all 0",
               {if_ack, dm_ack, mem_re, mem_we, busy}, mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    @(negedge clk); reset = 1'b0;
    exp_if_rd = '0; exp_dm_rd = '0;
  endtask

  task automatic test_contention;
    int cyc, re_n, we_n; bit side; logic [31:0] a, wd; exp_t e;
    if_req = 1; if_addr = 32'h80; dm_req = 1; dm_we = 0; dm_addr = 32'h200;
    sb.push_back('{1'b0, mem_fn(32'h80)});
    sb.push_back('{1'b1, mem_fn(32'h200)});
    for (int r = 0; r < 4; r++) begin
      wait_ack(12, cyc, side, re_n, we_n, a, wd);
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL contention_sb r=%0d unexpected ack, queue empty", r);
      end else begin
        e = sb.pop_front();
        if (cyc != ((r % 2 == 0) ? WC + 1 : WC + 2) || side != e.dm) begin
          errors++;
          $display("FAIL contention_order r=%0d cyc=%0d side=%0d want cyc=%0d side=%0d",
                   r, cyc, side, (r % 2 == 0) ? WC + 1 : WC + 2, e.dm);
        end
        checks++;
        if ((e.dm ? dm_rdata : if_rdata) !== e.rdata) begin
          errors++;
          $display("FAIL contention_rdata r=%0d got=%h want=%h", r,
                   e.dm ? dm_rdata : if_rdata, e.rdata);
        end
        if (e.dm) exp_dm_rd = e.rdata; else exp_if_rd = e.rdata;
      end
      if (side) dm_req = 0; else if_req = 0;
      if (r == 1) begin
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || if_ack !== 1'b0 || dm_ack !== 1'b0) begin
          errors++;
          $display("FAIL contention_idle busy=%b ifa=%b dma=%b want 0 0 0", busy, if_ack, dm_ack);
        end
        if_req = 1; dm_req = 1;
        sb.push_back('{1'b0, mem_fn(32'h80)});
        sb.push_back('{1'b1, mem_fn(32'h200)});
      end
    end
  endtask

  task automatic test_single_fetch;
    int cyc, re_n, we_n; bit side; logic [31:0] a, wd; exp_t e;
    @(negedge clk);
    if_req = 1; if_addr = 32'h40;
    sb.push_back('{1'b0, 32'h2001000A});
    wait_ack(12, cyc, side, re_n, we_n, a, wd);
    e = sb.pop_front();
    checks++;
    if (cyc != WC + 1 || side != e.dm || re_n != WC || we_n != 0 || a !== 32'h40) begin
      errors++;
      $display("FAIL fetch_seq cyc=%0d side=%0d re=%0d we=%0d addr=%h want %0d 0 %0d 0 00000040",
               cyc, side, re_n, we_n, a, WC + 1, WC);
    end
    checks++;
    if (if_rdata !== e.rdata || dm_rdata !== exp_dm_rd) begin
      errors++;
      $display("FAIL fetch_rdata ifrd=%h dmrd=%h want %h %h", if_rdata, dm_rdata, e.rdata, exp_dm_rd);
    end
    exp_if_rd = e.rdata;
    if_req = 0;
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL fetch_ack_width ifa=%b busy=%b want 0 0", if_ack, busy);
    end
  endtask

  task automatic test_store;
    int cyc, re_n, we_n; bit side; logic [31:0] a, wd; exp_t e;
    @(negedge clk);
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
    sb.push_back('{1'b1, exp_dm_rd});
    wait_ack(12, cyc, side, re_n, we_n, a, wd);
    e = sb.pop_front();
    checks++;
    if (cyc != WC + 1 || side != e.dm || we_n != WC || re_n != 0 ||
        a !== 32'h100 || wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_seq cyc=%0d side=%0d we=%0d re=%0d addr=%h wd=%h want %0d 1 %0d 0 00000100 deadbeef",
               cyc, side, we_n, re_n, a, wd, WC + 1, WC);
    end
    checks++;
    if (dm_rdata !== e.rdata || if_rdata !== exp_if_rd) begin
      errors++;
      $display("FAIL store_rdata dmrd=%h ifrd=%h want %h %h", dm_rdata, if_rdata, e.rdata, exp_if_rd);
    end
    dm_req = 0; dm_we = 0;
    @(negedge clk);
  endtask

  task automatic test_req_drop;
    int cyc, re_n, we_n; bit side; logic [31:0] a, wd; exp_t e;
    @(negedge clk);
    if_req = 1; if_addr = 32'h44;
    sb.push_back('{1'b0, mem_fn(32'h44)});
    @(negedge clk);
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== 32'h44) begin
      errors++; $display("FAIL drop_access re=%b addr=%h want 1 00000044", mem_re, mem_addr);
    end
    if_req = 0; if_addr = 32'h999;
    wait_ack(12, cyc, side, re_n, we_n, a, wd);
    e = sb.pop_front();
    checks++;
    if (cyc != WC || side != e.dm || (re_n != 0 && a !== 32'h44)) begin
      errors++;
      $display("FAIL drop_ack cyc=%0d side=%0d addr=%h want %0d 0 00000044", cyc, side, a, WC);
    end
    checks++;
    if (if_rdata !== e.rdata) begin
      errors++; $display("FAIL drop_rdata got=%h want=%h", if_rdata, e.rdata);
    end
    exp_if_rd = e.rdata;
    @(negedge clk);
  endtask

  task automatic test_abort;
    int cyc, re_n, we_n, acks; bit side; logic [31:0] a, wd; exp_t e;
    @(negedge clk);
    if_req = 1; if_addr = 32'h80;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1; if_req = 0;
    #1;
    checks++;
    if ({if_ack, dm_ack, mem_re, mem_we, busy} !== 5'b0 || mem_addr !== 32'h0 ||
        if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      errors++;
      $display("FAIL abort_reset ctl=%b addr=%h ifrd=%h dmrd=%h want all 0",
               {if_ack, dm_ack, mem_re, mem_we, busy}, mem_addr, if_rdata, dm_rdata);
    end
    @(negedge clk); reset = 1'b0;
    exp_if_rd = '0; exp_dm_rd = '0;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (if_ack || dm_ack || busy) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL abort_no_ack active_cycles=%0d want 0", acks);
    end
    if_req = 1; if_addr = 32'h40;
    sb.push_back('{1'b0, mem_fn(32'h40)});
    wait_ack(12, cyc, side, re_n, we_n, a, wd);
    e = sb.pop_front();
    checks++;
    if (cyc != WC + 1 || side != e.dm || if_rdata !== e.rdata) begin
      errors++;
      $display("FAIL abort_refetch cyc=%0d side=%0d rd=%h want %0d 0 %h", cyc, side, if_rdata, WC + 1, e.rdata);
    end
    if_req = 0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_contention();
    test_single_fetch();
    test_store();
    test_req_drop();
    test_abort();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover entries=%0d want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
